// File: rtl/tv_pkg.sv
// Shared types and default parameters for the test-vector sequencer.
//   tv_state_e : sequencer FSM states (IDLE / RUN / DONE)
//   DEF_*      : default parameter values
package tv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tv_state_e;

  localparam int unsigned DEF_IN_W  = 4;
  localparam int unsigned DEF_OUT_W = 2;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_HOLD  = 10;

endpackage

// File: rtl/tv_store.sv
// Vector storage: DEPTH entries of W bits, one synchronous write, one async read.
// Contents are deliberately not reset so loaded vectors survive rst.
//   clk     : clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata_c : combinational read data
module tv_store #(
  parameter  int unsigned W     = 6,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata_c
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: applies stored stimulus vectors to a DUT, holds each
// for HOLD cycles, compares the DUT response on the last hold cycle and counts
// mismatches. Supports single-pass and looping runs plus abort.
//   clk, rst                    : clock, async active-high reset
//   load_en/addr/vec/exp        : vector write port (ignored while running)
//   num_vec, loop, start, stop  : run control
//   dut_in, dut_out             : DUT stimulus / response
//   busy, done, mismatch        : status (mismatch is a 1-cycle pulse)
//   vec_idx, err_cnt            : current vector index, saturating error count
module tv_sequencer
  import tv_pkg::*;
#(
  parameter  int unsigned IN_W  = DEF_IN_W,
  parameter  int unsigned OUT_W = DEF_OUT_W,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned HOLD  = DEF_HOLD,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [IN_W-1:0]  load_vec,
  input  logic [OUT_W-1:0] load_exp,
  input  logic [AW:0]      num_vec,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [AW-1:0]    vec_idx,
  output logic [AW+7:0]    err_cnt
);

  localparam int unsigned W  = IN_W + OUT_W;
  localparam int unsigned HW = $clog2(HOLD + 1);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned EW = AW + 8;

  tv_state_e        state_q, state_d;
  logic [NW-1:0]    n_q, n_d, n_start_c;
  logic [HW-1:0]    hold_q, hold_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic [IN_W-1:0]  dut_in_d;
  logic             busy_d, done_d, mismatch_d;
  logic [AW-1:0]    vec_idx_d;
  logic [EW-1:0]    err_d;

  logic             we_c;
  logic [AW-1:0]    rd_addr_c;
  logic [W-1:0]     rd_data_c;
  logic             hold_last_c, last_vec_c;

  // Expected response is latched alongside dut_in, so a single read port suffices.
  tv_store #(.W(W), .DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .we      (we_c),
    .waddr   (load_addr),
    .wdata   ({load_vec, load_exp}),
    .raddr   (rd_addr_c),
    .rdata_c (rd_data_c)
  );

  assign we_c        = load_en && (state_q != ST_RUN);
  assign hold_last_c = (hold_q == HW'(HOLD - 1));
  assign last_vec_c  = (NW'(vec_idx) == (n_q - NW'(1)));
  assign n_start_c   = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
  // Next entry to present: successor while mid-pass, otherwise entry 0 (start or wrap).
  assign rd_addr_c   = ((state_q == ST_RUN) && !last_vec_c) ? (vec_idx + AW'(1)) : '0;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      hold_q   <= '0;
      exp_q    <= '0;
      dut_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      vec_idx  <= '0;
      err_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      hold_q   <= hold_d;
      exp_q    <= exp_d;
      dut_in   <= dut_in_d;
      busy     <= busy_d;
      done     <= done_d;
      mismatch <= mismatch_d;
      vec_idx  <= vec_idx_d;
      err_cnt  <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    hold_d     = hold_q;
    exp_d      = exp_q;
    dut_in_d   = dut_in;
    busy_d     = busy;
    done_d     = done;
    mismatch_d = 1'b0;
    vec_idx_d  = vec_idx;
    err_d      = err_cnt;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d       = n_start_c;
          err_d     = '0;
          vec_idx_d = '0;
          hold_d    = '0;
          if (n_start_c == '0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_RUN;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            dut_in_d = rd_data_c[W-1:OUT_W];
            exp_d    = rd_data_c[OUT_W-1:0];
          end
        end
      end

      ST_RUN: begin
        // Comparison on the final hold cycle lands even if stop aborts this edge.
        if (hold_last_c && (dut_out != exp_q)) begin
          mismatch_d = 1'b1;
          if (err_cnt != '1) err_d = err_cnt + EW'(1);
        end
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (hold_last_c) begin
          hold_d = '0;
          if (last_vec_c && !loop) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_idx_d = last_vec_c ? '0 : (vec_idx + AW'(1));
            dut_in_d  = rd_data_c[W-1:OUT_W];
            exp_d     = rd_data_c[OUT_W-1:0];
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tv_sequencer.sv
// Self-checking bench for tv_sequencer with a combinational DUT model.
module tb_tv_sequencer;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned HOLD  = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_en;
  logic [AW-1:0]    load_addr;
  logic [IN_W-1:0]  load_vec;
  logic [OUT_W-1:0] load_exp;
  logic [AW:0]      num_vec;
  logic             loop, start, stop;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy, done, mismatch;
  logic [AW-1:0]    vec_idx;
  logic [AW+7:0]    err_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [IN_W-1:0]  m_vec [DEPTH];
  logic [OUT_W-1:0] m_exp [DEPTH];

  tv_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_vec  (load_vec),
    .load_exp  (load_exp),
    .num_vec   (num_vec),
    .loop      (loop),
    .start     (start),
    .stop      (stop),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .vec_idx   (vec_idx),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] dut_model(input logic [3:0] v);
    logic a, b, c, d, t;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    t = ~a & (b | c);
    return {(~(d | b)) ^ (~t), d & ~t};
  endfunction

  assign dut_out = dut_model(dut_in);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [3:0] v, input logic [1:0] e);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_vec  = v;
    load_exp  = e;
    tick();
    load_en   = 1'b0;
    m_vec[a]  = v;
    m_exp[a]  = e;
  endtask

  function automatic int clampn(input int nv);
    return (nv > int'(DEPTH)) ? int'(DEPTH) : nv;
  endfunction

  function automatic int model_errs(input int n);
    int e = 0;
    for (int k = 0; k < n; k++) if (dut_model(m_vec[k]) != m_exp[k]) e++;
    return e;
  endfunction

  function automatic int model_first_mism(input int n);
    for (int k = 0; k < n; k++) if (dut_model(m_vec[k]) != m_exp[k]) return int'(HOLD) * (k + 1);
    return -1;
  endfunction

  // Single-pass run; poke_at >= 0 attempts a load and a restart mid-run.
  task automatic run_once(input string tag, input int nv, input int poke_at);
    int n, cyc, busy_cyc, mism_cnt, first_mism, din_bad;
    num_vec = (AW+1)'(nv);
    loop    = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    n = clampn(nv);
    if (n == 0) begin
      check({tag, "_n0_done"}, 32'(done), 32'd1);
      check({tag, "_n0_busy"}, 32'(busy), 32'd0);
      check({tag, "_n0_err"}, 32'(err_cnt), 32'd0);
      return;
    end
    cyc = 0; busy_cyc = 0; mism_cnt = 0; first_mism = -1; din_bad = 0;
    while (busy && cyc < 2000) begin
      if ((cyc / int'(HOLD)) < n && dut_in !== m_vec[cyc / int'(HOLD)]) din_bad++;
      if (cyc == poke_at) begin
        load_en = 1'b1; load_addr = '0; load_vec = 4'b1111; load_exp = 2'b00; start = 1'b1;
      end else begin
        load_en = 1'b0; start = 1'b0;
      end
      busy_cyc++;
      tick();
      cyc++;
      if (mismatch === 1'b1) begin
        mism_cnt++;
        if (first_mism < 0) first_mism = cyc;
      end
    end
    load_en = 1'b0; start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(int'(HOLD) * n));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(model_errs(n)));
    check({tag, "_mism_pulses"}, 32'(mism_cnt), 32'(model_errs(n)));
    check({tag, "_first_mism_cyc"}, 32'(first_mism), 32'(model_first_mism(n)));
    check({tag, "_din_bad"}, 32'(din_bad), 32'd0);
    check({tag, "_din_last"}, 32'(dut_in), 32'(m_vec[n-1]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int mism_cnt;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_vec = '0; load_exp = '0;
    num_vec = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_vec_idx", 32'(vec_idx), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_dut_in", 32'(dut_in), 32'd0);
    rst = 1'b0;
    tick();

    // Baseline table, all responses correct.
    load(0, 4'b0000, 2'b00);
    load(1, 4'b1111, 2'b11);
    load(2, 4'b0011, 2'b00);
    load(3, 4'b1100, 2'b10);
    load(4, 4'b1010, 2'b00);
    load(5, 4'b0101, 2'b00);
    run_once("basic", 6, -1);

    // Asynchronous reset mid-run.
    num_vec = 7'(6); start = 1'b1; tick(); start = 1'b0;
    repeat (25) tick();
    check("pre_rst_din", 32'(dut_in), 32'(m_vec[2]));
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_din", 32'(dut_in), 32'd0);
    check("async_rst_vec_idx", 32'(vec_idx), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    mism_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mismatch !== 1'b0 || done !== 1'b0 || busy !== 1'b0) mism_cnt++;
    end
    check("post_rst_quiet", 32'(mism_cnt), 32'd0);
    run_once("after_rst", 6, -1);

    // One wrong expectation.
    load(3, 4'b1100, 2'b11);
    run_once("one_err", 6, -1);

    // Looping: three passes, then stop together with start.
    num_vec = 7'(6); loop = 1'b1; start = 1'b1; tick(); start = 1'b0;
    mism_cnt = 0;
    for (int i = 1; i < 180; i++) begin
      tick();
      if (mismatch === 1'b1) mism_cnt++;
    end
    check("loop_idx_before_wrap", 32'(vec_idx), 32'd5);
    tick();
    if (mismatch === 1'b1) mism_cnt++;
    check("loop_idx_wrapped", 32'(vec_idx), 32'd0);
    check("loop_err_cnt", 32'(err_cnt), 32'(3 * model_errs(6)));
    check("loop_mism_pulses", 32'(mism_cnt), 32'(3 * model_errs(6)));
    check("loop_busy", 32'(busy), 32'd1);
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0; loop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_err_kept", 32'(err_cnt), 32'(3 * model_errs(6)));
    tick(); tick();
    check("stop_stays_idle", 32'(busy), 32'd0);

    // Empty run and clamped run.
    run_once("empty", 0, -1);
    load(6, 4'b1000, dut_model(4'b1000));
    load(7, 4'b0110, 2'b01);
    run_once("clamp", 15, -1);

    // Load and start during a run are ignored.
    run_once("poked", 6, 23);
    run_once("orig_contents", 6, -1);

    // Randomized tables and lengths.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        logic [3:0] v;
        logic [1:0] flip;
        v    = 4'($urandom);
        flip = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        load(a, v, dut_model(v) ^ flip);
      end
      run_once("rand", int'($urandom_range(0, 15)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tv_sequencer.md
TV_SEQUENCER -- requirements
Module: tv_sequencer

Interface
REQ-001 The block SHALL have parameter IN_W, default 4, giving the stimulus vector width applied to the device under test (DUT).
REQ-002 The block SHALL have parameter OUT_W, default 2, giving the DUT response width.
REQ-003 The block SHALL have parameter DEPTH, default 8 (power of 2, >=2), giving the number of stored vectors; AW = log2(DEPTH).
REQ-004 The block SHALL have parameter HOLD, default 10 (>=1), giving the number of clock cycles each vector is held.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have ports load_en (input, 1), load_addr (input, AW), load_vec (input, IN_W) and load_exp (input, OUT_W): the vector/expected-response write port.
REQ-008 The block SHALL have ports num_vec (input, AW+1) for vectors per pass, loop (input, 1) for repeat mode, start (input, 1) for a run pulse and stop (input, 1) for an abort pulse.
REQ-009 The block SHALL have ports dut_in (output, IN_W) driving the DUT stimulus and dut_out (input, OUT_W) receiving the combinational DUT response.
REQ-010 The block SHALL have status outputs busy (1), done (1), mismatch (1-cycle pulse), vec_idx (AW) and err_cnt (AW+8).

Function
REQ-011 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, load_en=1 SHALL write {load_vec, load_exp} to entry load_addr at the clock edge; load_en in RUN SHALL be ignored.
REQ-013 When start=1 in IDLE or DONE, the block SHALL: latch n = min(num_vec, DEPTH); clear err_cnt, vec_idx and the hold counter; drive dut_in = vec[0] from the next cycle; enter RUN with busy=1 and done=0.
REQ-014 In RUN, dut_in SHALL equal vec[vec_idx] and be held for exactly HOLD cycles per vector.
REQ-015 On the last hold cycle (hold counter = HOLD-1), the block SHALL compare dut_out with exp[vec_idx] at that edge; on inequality, mismatch SHALL be 1 in the following cycle and err_cnt SHALL increment.
REQ-016 err_cnt SHALL saturate at all-ones.
REQ-017 After comparing vector n-1 with loop=0, the block SHALL enter DONE: busy=0, done=1 (level), dut_in holding the last vector.
REQ-018 After comparing vector n-1 with loop=1, vec_idx SHALL wrap to 0 and RUN SHALL continue; err_cnt SHALL keep accumulating.
REQ-019 If n=0, start SHALL enter DONE on the next cycle with err_cnt=0 and busy never asserted.
REQ-020 stop=1 in RUN SHALL enter IDLE at the next edge: busy=0, done=0, err_cnt retained, no comparison for the current vector.
REQ-021 If start and stop are both 1, stop SHALL win; start in RUN SHALL be ignored.
REQ-022 The comparison and the err_cnt update SHALL take effect before the stop abort on the same edge.

Reset
REQ-023 rst=1 SHALL asynchronously force: state IDLE, dut_in=0, busy=0, done=0, mismatch=0, vec_idx=0, err_cnt=0, hold counter=0.
REQ-024 Vector storage SHALL NOT be reset; its contents SHALL be retained across rst.
REQ-025 Reset asserted mid-RUN SHALL abandon the run with no done pulse and no further mismatch.

Structure
REQ-026 Package tv_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default-parameter constants.
REQ-027 Storage SHALL be one sub-module, tv_store: DEPTH x (IN_W+OUT_W) registers with one synchronous write and one asynchronous read.

Verification
The bench models the DUT combinationally as X = ~(D|B) ^ ~(~A&(B|C)) and Y = D & ~(~A&(B|C)), with dut_in = {A,B,C,D} (A is the MSB) and dut_out = {X,Y}.
REQ-028 Load 0000/00, 1111/11, 0011/00, 1100/10, 1010/00, 0101/00; num_vec=6; start -> 60 RUN cycles, done=1, err_cnt=0, no mismatch.
REQ-029 Same run with entry 3 expected changed to 11 -> exactly one mismatch pulse at cycle 40 after start; err_cnt=1.
REQ-030 loop=1, num_vec=6, entry 3 = 11 -> after 3 passes err_cnt=3 and vec_idx wraps 5->0; stop then gives IDLE with busy=0 and done=0.
REQ-031 num_vec=0 -> done on the next cycle with err_cnt=0; num_vec=15 -> 8 vectors run (clamped to DEPTH).
REQ-032 rst pulse asynchronously at cycle 25 of a run -> outputs take their REQ-023 values immediately; a restart with no reload reproduces REQ-028 (storage retained).
REQ-033 load_en during RUN and start during RUN -> no effect; the next run uses the original contents.
